// File: rtl/ram_stream_reader.sv
// ram_stream_reader: reads len words from a registered-read RAM
// and streams them out on valid/ready with a last marker.
module ram_stream_reader #(
  parameter int WORD_WIDTH = 8,
  parameter int WORD_COUNT = 256
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic [$clog2(WORD_COUNT)-1:0] base_addr_i,
  input  logic [$clog2(WORD_COUNT):0]   len_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [$clog2(WORD_COUNT)-1:0] ram_addr_o,
  input  logic [WORD_WIDTH-1:0]   ram_data_i,
  output logic                    m_valid_o,
  input  logic                    m_ready_i,
  output logic [WORD_WIDTH-1:0]   m_data_o,
  output logic                    m_last_o
);

  localparam int AW = $clog2(WORD_COUNT);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]            state_q;
  logic                  a_v_q;
  logic                  b_v_q;
  logic [AW:0]           len_q;
  logic [AW:0]           issued_q;
  logic [AW:0]           sent_q;
  logic [WORD_WIDTH-1:0] fifo_q [4];
  logic [1:0]            wr_q;
  logic [1:0]            rd_q;
  logic [2:0]            cnt_q;

  logic [2:0] outstanding;
  logic       start_ok;
  logic       issue_run;
  logic       push;
  logic       pop;
  logic       last_hs;
  logic [AW-1:0] next_addr;

  assign outstanding = {2'b0, a_v_q} + {2'b0, b_v_q} + cnt_q;
  assign start_ok    = (state_q == S_IDLE) && start_i;
  assign issue_run   = (state_q == S_RUN) && (issued_q < len_q)
                     && (outstanding < 3'd4);
  assign push        = b_v_q;
  assign pop         = m_valid_o && m_ready_i;
  assign last_hs     = pop && m_last_o;
  assign next_addr   = (ram_addr_o == AW'(WORD_COUNT - 1))
                     ? '0 : ram_addr_o + AW'(1);

  assign busy_o    = (state_q != S_IDLE);
  assign done_o    = (state_q == S_DONE);
  assign m_valid_o = (cnt_q != 3'd0);
  assign m_data_o  = fifo_q[rd_q];
  assign m_last_o  = m_valid_o && (sent_q == len_q - (AW+1)'(1));

  // Transfer sequencing: idle, streaming, one-cycle done.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: if (start_i)
                  state_q <= (len_i == '0) ? S_DONE : S_RUN;
        S_RUN:  if (last_hs) state_q <= S_DONE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Read issue: address register, stage-A/B valids and counters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ram_addr_o <= '0;
      a_v_q      <= 1'b0;
      b_v_q      <= 1'b0;
      len_q      <= '0;
      issued_q   <= '0;
      sent_q     <= '0;
    end else begin
      b_v_q <= a_v_q;
      a_v_q <= 1'b0;
      if (start_ok) begin
        len_q    <= len_i;
        sent_q   <= '0;
        issued_q <= '0;
        if (len_i != '0) begin
          ram_addr_o <= base_addr_i;
          a_v_q      <= 1'b1;
          issued_q   <= (AW+1)'(1);
        end
      end else if (issue_run) begin
        ram_addr_o <= next_addr;
        a_v_q      <= 1'b1;
        issued_q   <= issued_q + (AW+1)'(1);
      end
      if (pop) sent_q <= sent_q + (AW+1)'(1);
    end
  end

  // Skid FIFO absorbing RAM latency under backpressure.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 4; i++) fifo_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_q] <= ram_data_i;
        wr_q         <= wr_q + 2'd1;
      end
      if (pop) rd_q <= rd_q + 2'd1;
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 3'd1;
        2'b01:   cnt_q <= cnt_q - 3'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  a_start_known: assert property (
    @(posedge clk_i) disable iff (rst_i) !$isunknown(start_i));
  a_ready_known: assert property (
    @(posedge clk_i) disable iff (rst_i) !$isunknown(m_ready_i));
  a_addr_range: assert property (
    @(posedge clk_i) disable iff (rst_i) int'(ram_addr_o) < WORD_COUNT);
  a_no_overflow: assert property (
    @(posedge clk_i) disable iff (rst_i) outstanding <= 3'd4);

endmodule

// File: tb/tb_ram_stream_reader.sv
// tb_ram_stream_reader: directed checks of the RAM stream reader
// using a 200-word registered-read RAM model holding ram[i]=i.
module tb_ram_stream_reader;

  localparam int WW = 8;
  localparam int WC = 200;
  localparam int AW = $clog2(WC);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base = '0;
  logic [AW:0]   len = '0;
  logic          busy, done;
  logic [AW-1:0] ram_addr;
  logic [WW-1:0] ram_q = '0;
  logic          m_valid, m_ready = 1'b0, m_last;
  logic [WW-1:0] m_data;
  logic [WW-1:0] mem [WC];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  always @(posedge clk)
    if (int'(ram_addr) < WC) ram_q <= mem[ram_addr];

  ram_stream_reader #(.WORD_WIDTH(WW), .WORD_COUNT(WC)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .base_addr_i(base), .len_i(len),
    .busy_o(busy), .done_o(done),
    .ram_addr_o(ram_addr), .ram_data_i(ram_q),
    .m_valid_o(m_valid), .m_ready_i(m_ready),
    .m_data_o(m_data), .m_last_o(m_last)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start a transfer and consume it; rnd gives ~50% ready,
  // poke re-requests a start at base 0x80 while busy.
  task automatic xfer(input int b, input int n, input bit rnd,
                      input bit poke);
    int cnt;
    bit stalled, got_done;
    logic [WW-1:0] hd;
    logic hl;
    cnt = 0; stalled = 0; got_done = 0; hd = '0; hl = 0;
    base = AW'(b); len = (AW+1)'(n); start = 1'b1;
    m_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (stalled) begin
        chk("stall_valid", 32'(m_valid), 32'd1);
        chk("stall_data", 32'(m_data), 32'(hd));
        chk("stall_last", 32'(m_last), 32'(hl));
      end
      if (poke && cyc == 2) begin
        base = AW'(8'h80); len = (AW+1)'(3); start = 1'b1;
      end else start = 1'b0;
      m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      stalled = m_valid && !m_ready;
      hd = m_data; hl = m_last;
      if (m_valid && m_ready) begin
        chk("data", 32'(m_data), 32'((b + cnt) % WC));
        chk("last", 32'(m_last), 32'(cnt == n - 1));
        cnt++;
      end
      tick();
      start = 1'b0;
      if (done) begin got_done = 1; break; end
    end
    chk("word_count", 32'(cnt), 32'(n));
    chk("done_seen", 32'(got_done), 32'd1);
    chk("done_no_valid", 32'(m_valid), 32'd0);
    tick();
    chk("done_pulse_end", 32'(done), 32'd0);
    chk("idle_after", 32'(busy), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < WC; i++) mem[i] = WW'(i);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_last", 32'(m_last), 32'd0);
    chk("rst_data", 32'(m_data), 32'd0);
    chk("rst_addr", 32'(ram_addr), 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // 1: base 0x10 len 4, exact latency
    base = AW'(8'h10); len = (AW+1)'(4); start = 1'b1;
    m_ready = 1'b1;
    tick();
    start = 1'b0;
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_addr0", 32'(ram_addr), 32'h10);
    chk("t1_v_e0", 32'(m_valid), 32'd0);
    tick();
    chk("t1_v_e1", 32'(m_valid), 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t1_valid", 32'(m_valid), 32'd1);
      chk("t1_data", 32'(m_data), 32'h10 + 32'(k));
      chk("t1_last", 32'(m_last), 32'(k == 3));
      chk("t1_done_lo", 32'(done), 32'd0);
    end
    tick();
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_v_off", 32'(m_valid), 32'd0);
    tick();
    chk("t1_done_off", 32'(done), 32'd0);
    chk("t1_idle", 32'(busy), 32'd0);

    // 2: address wrap 198,199,0,1
    base = AW'(198); len = (AW+1)'(4); start = 1'b1;
    tick();
    start = 1'b0;
    chk("t2_a0", 32'(ram_addr), 32'd198);
    tick();
    chk("t2_a1", 32'(ram_addr), 32'd199);
    tick();
    chk("t2_a2", 32'(ram_addr), 32'd0);
    chk("t2_d0", 32'(m_data), 32'd198);
    tick();
    chk("t2_a3", 32'(ram_addr), 32'd1);
    chk("t2_d1", 32'(m_data), 32'd199);
    tick();
    chk("t2_d2", 32'(m_data), 32'd0);
    chk("t2_hold", 32'(ram_addr), 32'd1);
    tick();
    chk("t2_d3", 32'(m_data), 32'd1);
    chk("t2_l3", 32'(m_last), 32'd1);
    tick();
    chk("t2_done", 32'(done), 32'd1);
    tick();

    // 3: len 0
    base = AW'(5); len = '0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t3_done", 32'(done), 32'd1);
    chk("t3_valid", 32'(m_valid), 32'd0);
    tick();
    chk("t3_done_off", 32'(done), 32'd0);
    chk("t3_valid2", 32'(m_valid), 32'd0);
    chk("t3_idle", 32'(busy), 32'd0);

    // 4: random backpressure, len 16
    xfer(8'h20, 16, 1'b1, 1'b0);
    xfer(190, 16, 1'b1, 1'b0);

    // 5: start while busy is ignored
    xfer(8'h30, 8, 1'b1, 1'b1);

    // full-depth transfer
    xfer(7, WC, 1'b0, 1'b0);

    // 6: reset after 3 words of len 10
    base = AW'(8'h40); len = (AW+1)'(10); start = 1'b1;
    m_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    chk("t6_pre_data", 32'(m_data), 32'h43);
    #2 rst = 1'b1;
    #1;
    chk("t6_valid", 32'(m_valid), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_addr", 32'(ram_addr), 32'd0);
    chk("t6_data", 32'(m_data), 32'd0);
    chk("t6_last", 32'(m_last), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t6_no_done", 32'(done), 32'd0);
    end
    rst = 1'b0;
    tick();
    chk("t6_idle", 32'(busy), 32'd0);
    xfer(8'h50, 3, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
